// File: rtl/p4bd_sync_sender.sv
// p4bd_sync_sender: clocked source for a 4-phase bundled-data channel.
// Words enter through a valid/ready port and wait in a small FIFO. A
// four-state FSM then drives each one onto out_req/out_data as the
// handshake initiator. out_ack is asynchronous and passes through a flop
// chain before the FSM uses it.
// Optional feature: define P4BD_ACK_TIMEOUT_EN to add an ack watchdog that
// sets the sticky ack_err flag.
module p4bd_sync_sender #(
    parameter int DWIDTH      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DWIDTH-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_req,
    output logic [DWIDTH-1:0]          out_data,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ack_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, RTZ} state_t;

    logic [DWIDTH-1:0]      mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   avail;
    logic                   push, pop, load, req_d;
    state_t                 state, state_d;

    // in_ready depends only on registered count, so a pop never reaches it
    // combinationally.
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign ack_s    = sync_q[SYNC_STAGES-1];

    // FIFO storage. It has no reset because stale entries are unreachable
    // once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy. Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // avail is a one-cycle-delayed "not empty" flag, so a fresh push reaches
    // the FSM one cycle later. After a pop the FSM spends at least two
    // cycles in SETUP/REQ_HI, so the lag never exposes a stale value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) avail <= 1'b0;
        else        avail <= (count != '0);
    end

    // Synchronize the asynchronous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], out_ack};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // FSM next state, pop/load strobes and next request level.
    // No new word starts while ack_s is still high, which also covers a
    // receiver that keeps ack asserted across a reset.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        load    = 1'b0;
        req_d   = 1'b0;
        case (state)
            IDLE: begin
                if (avail && !ack_s) begin
                    load    = 1'b1;
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = 1'b1;
                state_d = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s) state_d = RTZ;
                else       req_d   = 1'b1;
            end
            RTZ: begin
                if (!ack_s) begin
                    if (avail) begin
                        load    = 1'b1;
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered channel outputs. out_data changes only when entering SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_req  <= 1'b0;
            out_data <= '0;
        end else begin
            out_req <= req_d;
            if (load) out_data <= mem[rd_ptr];
        end
    end

`ifdef P4BD_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;
    logic          waiting, wd_entry;

    assign waiting  = (state == REQ_HI) || (state == RTZ);
    assign wd_entry = (state_d != state) && ((state_d == REQ_HI) || (state_d == RTZ));

    // Watchdog counter. It restarts on entry to each waiting state and
    // saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    wd_cnt <= '0;
        else if (wd_entry)                             wd_cnt <= '0;
        else if (waiting && wd_cnt != TW'(TIMEOUT))    wd_cnt <= wd_cnt + TW'(1);
    end

    // Sticky error, set on the edge where the counter reaches TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                ack_err <= 1'b0;
        else if (waiting && !wd_entry && wd_cnt == TW'(TIMEOUT - 1)) ack_err <= 1'b1;
    end
`else
    assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_p4bd_sync_sender.sv
// Self-checking bench for p4bd_sync_sender. It includes a 4-phase receiver
// model and a scoreboard of words that were pushed and words that were
// received.
module tb_p4bd_sync_sender;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_req;
    logic [7:0] out_data;
    logic       out_ack;
    logic [2:0] count;
    logic       ack_err;

    // The ack source is either the automatic receiver or the test task.
    logic       man_mode = 1'b0;
    logic       man_ack  = 1'b0;
    logic       auto_ack = 1'b0;
    int         rcv_dly  = 1;
    assign out_ack = man_mode ? man_ack : auto_ack;

    logic [7:0] sb[$];   // expected words, pushed by stimulus
    logic [7:0] rx_q[$]; // words taken by the receiver

    int tests = 0;
    int fails = 0;

    p4bd_sync_sender #(.DWIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_req(out_req), .out_data(out_data),
        .out_ack(out_ack), .count(count), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // 4-phase receiver: it acks rcv_dly negedges after req rises and
    // releases ack once req has fallen.
    initial begin
        int w = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || man_mode) begin
                auto_ack = 1'b0;
                w = 0;
            end else if (out_req && !auto_ack) begin
                if (w >= rcv_dly) begin
                    rx_q.push_back(out_data);
                    auto_ack = 1'b1;
                    w = 0;
                end else w++;
            end else if (!out_req && auto_ack) begin
                auto_ack = 1'b0;
            end
        end
    end

    task automatic push_word(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL push_ready: in_ready=%0b required 1 (word %02h)", in_ready, d);
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            sb.push_back(d);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_req(input logic lvl, input string name);
        int n = 0;
        @(negedge clk);
        while (out_req !== lvl && n < 200) begin @(negedge clk); n++; end
        tests++;
        if (out_req !== lvl) begin
            fails++;
            $display("FAIL %s: out_req=%0b required %0b (timeout)", name, out_req, lvl);
        end
    endtask

    // Wait for the channel to go quiet, then compare received words with the scoreboard.
    task automatic drain(input string name);
        int n = 0;
        logic [7:0] e, a;
        @(negedge clk);
        while (!(rx_q.size() >= sb.size() && !out_req && !out_ack && count == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_drain: rx=%0d words required %0d (timeout)", name, rx_q.size(), sb.size());
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (rx_q.size() == 0) begin
                fails++;
                $display("FAIL %s_data: missing word, required %02h", name, e);
            end else begin
                a = rx_q.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL %s_data: got %02h required %02h", name, a, e);
                end
            end
        end
        tests++;
        if (rx_q.size() != 0) begin
            fails++;
            $display("FAIL %s_extra: %0d unexpected words received, required 0", name, rx_q.size());
            rx_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        tests += 5;
        if (out_req !== 1'b0)  begin fails++; $display("FAIL rst_req: %0b required 0", out_req); end
        if (out_data !== 8'h0) begin fails++; $display("FAIL rst_data: %02h required 00", out_data); end
        if (count !== 3'd0)    begin fails++; $display("FAIL rst_count: %0d required 0", count); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: %0b required 1", in_ready); end
        if (ack_err !== 1'b0)  begin fails++; $display("FAIL rst_err: %0b required 0", ack_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        rcv_dly = 3;
        push_word(8'hA5);               // returns 1ns after edge N
        tests++;
        if (count !== 3'd1) begin fails++; $display("FAIL single_cnt: %0d required 1", count); end
        @(posedge clk); #1;             // N+1
        tests++;
        if (out_req !== 1'b0) begin fails++; $display("FAIL single_req_n1: %0b required 0", out_req); end
        @(posedge clk); #1;             // N+2: data set up, req still low
        tests += 2;
        if (out_data !== 8'hA5) begin fails++; $display("FAIL single_data_n2: %02h required a5", out_data); end
        if (out_req !== 1'b0)   begin fails++; $display("FAIL single_req_n2: %0b required 0", out_req); end
        @(posedge clk); #1;             // N+3: req rises
        tests++;
        if (out_req !== 1'b1) begin fails++; $display("FAIL single_req_n3: %0b required 1", out_req); end
        drain("single");
        tests++;
        if (count !== 3'd0) begin fails++; $display("FAIL single_cnt_end: %0d required 0", count); end
        rcv_dly = 1;
    endtask

    task automatic test_fill();
        man_mode = 1'b1;
        man_ack  = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        @(negedge clk);
        tests += 4;
        if (count !== 3'd4)    begin fails++; $display("FAIL fill_count: %0d required 4", count); end
        if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_ready: %0b required 0", in_ready); end
        if (out_req !== 1'b1)  begin fails++; $display("FAIL fill_req: %0b required 1", out_req); end
        if (out_data !== 8'h01) begin fails++; $display("FAIL fill_head: %02h required 01", out_data); end
        man_mode = 1'b0;
        drain("fill");
    endtask

    task automatic test_simul();
        logic [7:0] e;
        man_mode = 1'b1;
        man_ack  = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'hA0 + 8'(i));
        for (int i = 3; i < 6; i++) begin
            wait_req(1'b1, "simul_req_hi");
            e = sb.pop_front();
            tests++;
            if (out_data !== e) begin fails++; $display("FAIL simul_data: %02h required %02h", out_data, e); end
            man_ack = 1'b1;
            wait_req(1'b0, "simul_req_lo");
            man_ack = 1'b0;
            // ack_s falls after two edges, so the RTZ pop lands on the third.
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (count !== 3'd2) begin fails++; $display("FAIL simul_pre: count=%0d required 2", count); end
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            sb.push_back(in_data);
            @(posedge clk);
            #1 in_valid = 1'b0;
            tests++;
            if (count !== 3'd2) begin fails++; $display("FAIL simul_hold: count=%0d required 2", count); end
        end
        man_mode = 1'b0;
        drain("simul");
    endtask

    task automatic test_reset_mid();
        logic ok = 1'b1;
        man_mode = 1'b1;
        man_ack  = 1'b0;
        push_word(8'h77);
        push_word(8'h78);
        wait_req(1'b1, "rmid_req_hi");
        man_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests += 2;
        if (out_req !== 1'b0) begin fails++; $display("FAIL rmid_req: %0b required 0", out_req); end
        if (count !== 3'd0)   begin fails++; $display("FAIL rmid_count: %0d required 0", count); end
        sb.delete();
        rx_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push_word(8'h3C);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_req !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL rmid_hold: out_req rose while ack held high, required 0"); end
        man_ack  = 1'b0;
        man_mode = 1'b0;
        drain("rmid");
    endtask

    task automatic test_wrap();
        rcv_dly = 0;
        for (int i = 0; i < 10; i++) push_word(8'h10 + 8'(i));
        drain("wrap");
        rcv_dly = 1;
    endtask

    task automatic test_watchdog();
        logic [7:0] e;
        man_mode = 1'b1;
        man_ack  = 1'b0;
        push_word(8'h5A);
        wait_req(1'b1, "wd_req_hi");    // negedge just after the REQ_HI entry edge
`ifdef P4BD_ACK_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            tests++;
            if (ack_err !== (i == 8)) begin
                fails++;
                $display("FAIL wd_err_cyc%0d: %0b required %0b", i, ack_err, (i == 8));
            end
        end
`else
        repeat (20) @(negedge clk);
        tests++;
        if (ack_err !== 1'b0) begin fails++; $display("FAIL wd_err_off: %0b required 0", ack_err); end
`endif
        tests++;
        if (out_req !== 1'b1) begin fails++; $display("FAIL wd_req_hold: %0b required 1", out_req); end
        e = sb.pop_front();
        tests++;
        if (out_data !== e) begin fails++; $display("FAIL wd_data: %02h required %02h", out_data, e); end
        man_ack = 1'b1;
        wait_req(1'b0, "wd_req_lo");
        man_ack  = 1'b0;
        man_mode = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_reset_mid();
        test_wrap();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
